// File: rtl/laser_point_feeder_if.sv
// Solver-side link of the LASER point interface: point stream out, centres and DONE back.
// The master modport is the feeder; the slave modport is the solver.
interface laser_point_feeder_if;
   logic [3:0] X;
   logic [3:0] Y;
   logic       X_VLD;
   logic       DONE;
   logic [3:0] C1X;
   logic [3:0] C1Y;
   logic [3:0] C2X;
   logic [3:0] C2Y;

   modport master (
      output X, Y, X_VLD,
      input  DONE, C1X, C1Y, C2X, C2Y
   );

   modport slave (
      input  X, Y, X_VLD,
      output DONE, C1X, C1Y, C2X, C2Y
   );
endinterface

// File: rtl/laser_point_feeder.sv
// LASER point feeder: streams stored points to the solver, waits for DONE, scores the centres.
// Build option LASER_FEED_SCORE_EN enables the SCORE state and distance datapath.
module laser_point_feeder #(
   parameter int unsigned NUM_PTS   = 40,
   parameter int unsigned RADIUS_SQ = 16,
   parameter int unsigned TIMEOUT   = 4096
) (
   input  logic                        CLK,
   input  logic                        RST,
   input  logic                        LD_EN,
   input  logic [5:0]                  LD_ADDR,
   input  logic [3:0]                  LD_X,
   input  logic [3:0]                  LD_Y,
   input  logic                        START,
   laser_point_feeder_if.master        sol,
   output logic                        BUSY,
   output logic [5:0]                  SCORE,
   output logic                        SCORE_VLD,
   output logic                        TO_ERR
);

   localparam int unsigned IdxW = (NUM_PTS > 1) ? $clog2(NUM_PTS) : 1;
   localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {StIdle, StSend, StWait, StScore, StReport} state_e;

   state_e state_q, state_d;

   logic [IdxW-1:0] idx_q, idx_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            to_err_q, to_err_d;
   logic [3:0]      c1x_q, c1y_q, c2x_q, c2y_q;

   logic [3:0] mem_x [NUM_PTS];
   logic [3:0] mem_y [NUM_PTS];

   logic start_acc;
   logic ld_we;
   logic done_acc;
   logic last_idx;
   logic timeout_hit;

   assign start_acc   = (state_q == StIdle) && START;
   assign ld_we       = (state_q == StIdle) && LD_EN && ({26'd0, LD_ADDR} < NUM_PTS);
   assign done_acc    = (state_q == StWait) && sol.DONE;
   assign last_idx    = (idx_q == IdxW'(NUM_PTS - 1));
   assign timeout_hit = (cnt_q == CntW'(TIMEOUT - 1));

   // Point memory is deliberately left out of reset so patterns survive an abort.
   always_ff @(posedge CLK) begin
      if (ld_we) begin
         mem_x[LD_ADDR[IdxW-1:0]] <= LD_X;
         mem_y[LD_ADDR[IdxW-1:0]] <= LD_Y;
      end
   end

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (START) state_d = StSend;
         StSend:   if (last_idx) state_d = StWait;
         StWait: begin
            // DONE takes priority over a coincident timeout.
            if (sol.DONE) begin
`ifdef LASER_FEED_SCORE_EN
               state_d = StScore;
`else
               state_d = StReport;
`endif
            end else if (timeout_hit) begin
               state_d = StReport;
            end
         end
         StScore:  if (last_idx) state_d = StReport;
         StReport: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Memory read is combinational so a write accepted with START is already visible at point 0.
   always_comb begin
      sol.X_VLD = (state_q == StSend);
      sol.X     = 4'd0;
      sol.Y     = 4'd0;
      if (state_q == StSend) begin
         sol.X = mem_x[idx_q];
         sol.Y = mem_y[idx_q];
      end
      BUSY      = (state_q != StIdle);
      SCORE_VLD = (state_q == StReport);
   end

   // ---------------------------------------------------------------- Control datapath
   always_comb begin
      idx_d = '0;
      if ((state_q == StSend) || (state_q == StScore)) begin
         idx_d = last_idx ? '0 : idx_q + 1'b1;
      end

      cnt_d = '0;
      if (state_q == StWait) begin
         cnt_d = cnt_q + 1'b1;
      end

      to_err_d = to_err_q;
      if (start_acc) begin
         to_err_d = 1'b0;
      end else if ((state_q == StWait) && !sol.DONE && timeout_hit) begin
         to_err_d = 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         idx_q    <= '0;
         cnt_q    <= '0;
         to_err_q <= 1'b0;
         c1x_q    <= '0;
         c1y_q    <= '0;
         c2x_q    <= '0;
         c2y_q    <= '0;
      end else begin
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         to_err_q <= to_err_d;
         if (done_acc) begin
            c1x_q <= sol.C1X;
            c1y_q <= sol.C1Y;
            c2x_q <= sol.C2X;
            c2y_q <= sol.C2Y;
         end
      end
   end

   assign TO_ERR = to_err_q;

`ifdef LASER_FEED_SCORE_EN
   // ---------------------------------------------------------------- Scoring datapath
   localparam logic [8:0] RadSq = 9'(RADIUS_SQ);

   logic [5:0] acc_q, acc_d;
   logic [5:0] score_q, score_d;
   logic [3:0] px, py;
   logic [8:0] d1sq, d2sq;
   logic       covered;

   function automatic logic [7:0] sq_diff(input logic [3:0] a, input logic [3:0] b);
      logic signed [4:0] d;
      logic [3:0]        m;
      d = $signed({1'b0, a}) - $signed({1'b0, b});
      m = d[4] ? 4'(-d) : d[3:0];
      return {4'd0, m} * {4'd0, m};
   endfunction

   assign px      = mem_x[idx_q];
   assign py      = mem_y[idx_q];
   assign d1sq    = {1'b0, sq_diff(px, c1x_q)} + {1'b0, sq_diff(py, c1y_q)};
   assign d2sq    = {1'b0, sq_diff(px, c2x_q)} + {1'b0, sq_diff(py, c2y_q)};
   assign covered = (d1sq <= RadSq) || (d2sq <= RadSq);

   always_comb begin
      acc_d   = acc_q;
      score_d = score_q;
      if (start_acc) begin
         acc_d   = '0;
         score_d = '0;
      end else if (state_q == StScore) begin
         acc_d = acc_q + {5'd0, covered};
         if (last_idx) begin
            score_d = acc_q + {5'd0, covered};
         end
      end else if ((state_q == StWait) && !sol.DONE && timeout_hit) begin
         score_d = '0;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         acc_q   <= '0;
         score_q <= '0;
      end else begin
         acc_q   <= acc_d;
         score_q <= score_d;
      end
   end

   assign SCORE = score_q;
`else
   // Centres are still captured for observability even though nothing scores them.
   logic unused_centres;
   assign unused_centres = ^{c1x_q, c1y_q, c2x_q, c2y_q};
   assign SCORE          = 6'd0;
`endif

endmodule

// File: tb/tb_laser_point_feeder.sv
// Directed self-checking bench for laser_point_feeder (TIMEOUT shortened to 16).
module tb_laser_point_feeder;
`ifdef LASER_FEED_SCORE_EN
   localparam bit ScoreEn = 1'b1;
`else
   localparam bit ScoreEn = 1'b0;
`endif
   localparam int NumPts = 40;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       LD_EN = 1'b0;
   logic [5:0] LD_ADDR = '0;
   logic [3:0] LD_X = '0;
   logic [3:0] LD_Y = '0;
   logic       START = 1'b0;
   logic       BUSY;
   logic [5:0] SCORE;
   logic       SCORE_VLD;
   logic       TO_ERR;

   laser_point_feeder_if sol_if ();

   laser_point_feeder #(
      .NUM_PTS  (NumPts),
      .RADIUS_SQ(16),
      .TIMEOUT  (16)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .LD_EN    (LD_EN),
      .LD_ADDR  (LD_ADDR),
      .LD_X     (LD_X),
      .LD_Y     (LD_Y),
      .START    (START),
      .sol      (sol_if.master),
      .BUSY     (BUSY),
      .SCORE    (SCORE),
      .SCORE_VLD(SCORE_VLD),
      .TO_ERR   (TO_ERR)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_fail   = 0;

   logic [3:0] xs [64];
   logic [3:0] ys [64];
   int         nvld;
   int         pulses;
   int         wait_ticks;
   logic [5:0] r_score;
   logic       r_to_err;
   logic       busy_after;
   logic       first_to_err;
   logic [5:0] first_score;

   task automatic load_pt(input int a, input logic [3:0] x, input logic [3:0] y);
      @(negedge CLK);
      LD_EN = 1'b1; LD_ADDR = 6'(a); LD_X = x; LD_Y = y;
      @(negedge CLK);
      LD_EN = 1'b0;
   endtask

   task automatic load_all(input logic [3:0] x, input logic [3:0] y);
      for (int i = 0; i < NumPts; i++) begin
         @(negedge CLK);
         LD_EN = 1'b1; LD_ADDR = 6'(i); LD_X = x; LD_Y = y;
      end
      @(negedge CLK);
      LD_EN = 1'b0;
   endtask

   // One START..REPORT run; records the point stream and the report observations.
   task automatic run(input bit send_done, input logic [3:0] c1x, input logic [3:0] c1y,
                      input logic [3:0] c2x, input logic [3:0] c2y, input bit ld_with_start,
                      input logic [5:0] la, input logic [3:0] lx, input logic [3:0] ly);
      @(negedge CLK);
      START = 1'b1;
      if (ld_with_start) begin
         LD_EN = 1'b1; LD_ADDR = la; LD_X = lx; LD_Y = ly;
      end
      @(negedge CLK);
      START = 1'b0; LD_EN = 1'b0;
      first_to_err = TO_ERR;
      first_score  = SCORE;
      nvld = 0;
      while (sol_if.X_VLD === 1'b1 && nvld < 64) begin
         xs[nvld] = sol_if.X;
         ys[nvld] = sol_if.Y;
         nvld++;
         @(negedge CLK);
      end
      if (send_done) begin
         sol_if.DONE = 1'b1;
         sol_if.C1X = c1x; sol_if.C1Y = c1y; sol_if.C2X = c2x; sol_if.C2Y = c2y;
         @(negedge CLK);
         sol_if.DONE = 1'b0;
      end
      pulses = 0; wait_ticks = -1; busy_after = 1'b1; r_score = 6'h3f; r_to_err = 1'bx;
      for (int i = 0; i < 200; i++) begin
         if (SCORE_VLD === 1'b1) begin
            pulses++;
            if (wait_ticks < 0) begin
               wait_ticks = i; r_score = SCORE; r_to_err = TO_ERR;
            end
         end else if (wait_ticks >= 0) begin
            busy_after = BUSY;
            break;
         end
         @(negedge CLK);
      end
   endtask

   task automatic test_reset;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      n_checks++; if (sol_if.X_VLD !== 1'b0) begin n_fail++; $display("FAIL reset_x_vld: got %b want 0", sol_if.X_VLD); end
      n_checks++; if (sol_if.X !== 4'd0) begin n_fail++; $display("FAIL reset_x: got %0d want 0", sol_if.X); end
      n_checks++; if (sol_if.Y !== 4'd0) begin n_fail++; $display("FAIL reset_y: got %0d want 0", sol_if.Y); end
      n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", BUSY); end
      n_checks++; if (SCORE !== 6'd0) begin n_fail++; $display("FAIL reset_score: got %0d want 0", SCORE); end
      n_checks++; if (SCORE_VLD !== 1'b0) begin n_fail++; $display("FAIL reset_score_vld: got %b want 0", SCORE_VLD); end
      n_checks++; if (TO_ERR !== 1'b0) begin n_fail++; $display("FAIL reset_to_err: got %b want 0", TO_ERR); end
      RST = 1'b0;
   endtask

   task automatic test_full_cover;
      int bad;
      load_all(4'd8, 4'd8);
      run(1'b1, 4'd8, 4'd8, 4'd0, 4'd0, 1'b0, 6'd0, 4'd0, 4'd0);
      n_checks++; if (nvld != 40) begin n_fail++; $display("FAIL full_xvld_len: got %0d want 40", nvld); end
      bad = 0;
      for (int i = 0; i < 40; i++) if (xs[i] !== 4'd8 || ys[i] !== 4'd8) bad++;
      n_checks++; if (bad != 0) begin n_fail++; $display("FAIL full_stream: got %0d bad points want 0", bad); end
      n_checks++; if (r_score !== (ScoreEn ? 6'd40 : 6'd0)) begin n_fail++; $display("FAIL full_score: got %0d want %0d", r_score, ScoreEn ? 40 : 0); end
      n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL full_vld_pulse: got %0d want 1", pulses); end
      n_checks++; if (r_to_err !== 1'b0) begin n_fail++; $display("FAIL full_to_err: got %b want 0", r_to_err); end
      n_checks++; if (busy_after !== 1'b0) begin n_fail++; $display("FAIL full_busy_after: got %b want 0", busy_after); end
   endtask

   task automatic test_overlap;
      run(1'b1, 4'd8, 4'd8, 4'd8, 4'd8, 1'b0, 6'd0, 4'd0, 4'd0);
      n_checks++; if (first_score !== 6'd0) begin n_fail++; $display("FAIL overlap_score_cleared: got %0d want 0", first_score); end
      n_checks++; if (r_score !== (ScoreEn ? 6'd40 : 6'd0)) begin n_fail++; $display("FAIL overlap_score: got %0d want %0d", r_score, ScoreEn ? 40 : 0); end
   endtask

   task automatic test_no_cover;
      load_all(4'd0, 4'd0);
      run(1'b1, 4'd15, 4'd15, 4'd15, 4'd0, 1'b0, 6'd0, 4'd0, 4'd0);
      n_checks++; if (r_score !== 6'd0) begin n_fail++; $display("FAIL nocover_score: got %0d want 0", r_score); end
      n_checks++; if (r_to_err !== 1'b0) begin n_fail++; $display("FAIL nocover_to_err: got %b want 0", r_to_err); end
      n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL nocover_vld_pulse: got %0d want 1", pulses); end
   endtask

   // (12,8) and (15,11) sit exactly on the radius; (11,11) and (13,8) are just outside.
   task automatic test_boundary;
      load_all(4'd0, 4'd15);
      load_pt(1, 4'd15, 4'd11);
      load_pt(2, 4'd11, 4'd11);
      load_pt(3, 4'd13, 4'd8);
      run(1'b1, 4'd8, 4'd8, 4'd15, 4'd15, 1'b1, 6'd0, 4'd12, 4'd8);
      n_checks++; if (xs[0] !== 4'd12 || ys[0] !== 4'd8) begin n_fail++; $display("FAIL bnd_pt0_ld_with_start: got (%0d,%0d) want (12,8)", xs[0], ys[0]); end
      n_checks++; if (xs[1] !== 4'd15 || ys[1] !== 4'd11) begin n_fail++; $display("FAIL bnd_pt1: got (%0d,%0d) want (15,11)", xs[1], ys[1]); end
      n_checks++; if (xs[39] !== 4'd0 || ys[39] !== 4'd15) begin n_fail++; $display("FAIL bnd_pt39: got (%0d,%0d) want (0,15)", xs[39], ys[39]); end
      n_checks++; if (r_score !== (ScoreEn ? 6'd2 : 6'd0)) begin n_fail++; $display("FAIL bnd_score: got %0d want %0d", r_score, ScoreEn ? 2 : 0); end
   endtask

   task automatic test_timeout;
      run(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 6'd0, 4'd0, 4'd0);
      n_checks++; if (wait_ticks != 16) begin n_fail++; $display("FAIL to_wait_cycles: got %0d want 16", wait_ticks); end
      n_checks++; if (r_to_err !== 1'b1) begin n_fail++; $display("FAIL to_err_set: got %b want 1", r_to_err); end
      n_checks++; if (r_score !== 6'd0) begin n_fail++; $display("FAIL to_score: got %0d want 0", r_score); end
      n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL to_vld_pulse: got %0d want 1", pulses); end
      n_checks++; if (busy_after !== 1'b0) begin n_fail++; $display("FAIL to_busy_after: got %b want 0", busy_after); end
      @(negedge CLK); sol_if.DONE = 1'b1;
      @(negedge CLK); sol_if.DONE = 1'b0;
      @(negedge CLK);
      n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL to_late_done_busy: got %b want 0", BUSY); end
      n_checks++; if (TO_ERR !== 1'b1) begin n_fail++; $display("FAIL to_err_sticky: got %b want 1", TO_ERR); end
      // Memory still holds the boundary pattern: only (12,8) lies within 4 of (8,8).
      run(1'b1, 4'd8, 4'd8, 4'd8, 4'd8, 1'b0, 6'd0, 4'd0, 4'd0);
      n_checks++; if (first_to_err !== 1'b0) begin n_fail++; $display("FAIL to_err_clear_on_start: got %b want 0", first_to_err); end
      n_checks++; if (r_to_err !== 1'b0) begin n_fail++; $display("FAIL to_err_after_done: got %b want 0", r_to_err); end
      n_checks++; if (r_score !== (ScoreEn ? 6'd1 : 6'd0)) begin n_fail++; $display("FAIL to_rerun_score: got %0d want %0d", r_score, ScoreEn ? 1 : 0); end
   endtask

   task automatic test_midrun_reset;
      int vld_seen;
      load_all(4'd8, 4'd8);
      load_pt(0, 4'd3, 4'd5);
      @(negedge CLK); START = 1'b1;
      @(negedge CLK); START = 1'b0;
      repeat (20) @(negedge CLK);
      n_checks++; if (sol_if.X_VLD !== 1'b1 || sol_if.X !== 4'd8) begin n_fail++; $display("FAIL mid_pt20: got vld=%b x=%0d want vld=1 x=8", sol_if.X_VLD, sol_if.X); end
      #2 RST = 1'b1;
      #1;
      n_checks++; if (sol_if.X_VLD !== 1'b0) begin n_fail++; $display("FAIL mid_xvld_async: got %b want 0", sol_if.X_VLD); end
      n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL mid_busy_async: got %b want 0", BUSY); end
      n_checks++; if (sol_if.X !== 4'd0 || sol_if.Y !== 4'd0) begin n_fail++; $display("FAIL mid_xy_zero: got (%0d,%0d) want (0,0)", sol_if.X, sol_if.Y); end
      @(negedge CLK); RST = 1'b0;
      vld_seen = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge CLK);
         if (SCORE_VLD === 1'b1 || BUSY === 1'b1) vld_seen++;
      end
      n_checks++; if (vld_seen != 0) begin n_fail++; $display("FAIL mid_no_report: got %0d active cycles want 0", vld_seen); end
      run(1'b1, 4'd8, 4'd8, 4'd0, 4'd0, 1'b0, 6'd0, 4'd0, 4'd0);
      n_checks++; if (xs[0] !== 4'd3 || ys[0] !== 4'd5) begin n_fail++; $display("FAIL mid_replay_pt0: got (%0d,%0d) want (3,5)", xs[0], ys[0]); end
      n_checks++; if (nvld != 40) begin n_fail++; $display("FAIL mid_replay_len: got %0d want 40", nvld); end
      n_checks++; if (r_score !== (ScoreEn ? 6'd39 : 6'd0)) begin n_fail++; $display("FAIL mid_replay_score: got %0d want %0d", r_score, ScoreEn ? 39 : 0); end
   endtask

   initial begin
      sol_if.DONE = 1'b0;
      sol_if.C1X = '0; sol_if.C1Y = '0; sol_if.C2X = '0; sol_if.C2Y = '0;
      test_reset();
      test_full_cover();
      test_overlap();
      test_no_cover();
      test_boundary();
      test_timeout();
      test_midrun_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
